// File: rtl/binary_gcd_engine_pkg.sv
// gcd_pkg: shared state encoding and width helpers for binary_gcd_engine.
`default_nettype none

package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The shift count k can reach WIDTH-1, so clog2(WIDTH)+1 bits always suffice.
  function automatic int k_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // The step count is at most 2*WIDTH+1.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 2);
  endfunction

  localparam int DEF_WIDTH = 16;
  localparam int K_W       = k_width(DEF_WIDTH);
  localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

`default_nettype wire

// File: rtl/binary_gcd_engine_if.sv
// binary_gcd_engine_if: Begin/Complete handshake bundle for the GCD engine.
`default_nettype none

interface binary_gcd_engine_if #(
  parameter int WIDTH = 16
);
  logic             Begin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             Complete;
  logic [WIDTH-1:0] gcd;
`ifdef GCD_STEP_COUNT_EN
  logic [$clog2(2*WIDTH+2)-1:0] steps;

  modport master (output Begin, a, b, input busy, Complete, gcd, steps);
  modport slave  (input Begin, a, b, output busy, Complete, gcd, steps);
`else
  modport master (output Begin, a, b, input busy, Complete, gcd);
  modport slave  (input Begin, a, b, output busy, Complete, gcd);
`endif
endinterface

`default_nettype wire

// File: rtl/binary_gcd_engine_step.sv
// binary_gcd_step: one combinational Stein iteration on (x, y, k).
`default_nettype none

module binary_gcd_step #(
  parameter int WIDTH = 16,
  parameter int K_W   = 5
) (
  input  wire logic [WIDTH-1:0] i_x,
  input  wire logic [WIDTH-1:0] i_y,
  input  wire logic [K_W-1:0]   i_k,
  output logic      [WIDTH-1:0] o_x,
  output logic      [WIDTH-1:0] o_y,
  output logic      [K_W-1:0]   o_k,
  output logic                  o_finish,
  output logic      [WIDTH-1:0] o_result
);

  always_comb begin
    o_x      = i_x;
    o_y      = i_y;
    o_k      = i_k;
    o_finish = 1'b0;
    o_result = '0;
    if (i_x == '0) begin
      o_finish = 1'b1;
      o_result = i_y << i_k;
    end else if (i_y == '0) begin
      o_finish = 1'b1;
      o_result = i_x << i_k;
    end else if (!i_x[0] && !i_y[0]) begin
      o_x = i_x >> 1;
      o_y = i_y >> 1;
      o_k = i_k + K_W'(1);
    end else if (!i_x[0]) begin
      o_x = i_x >> 1;
    end else if (!i_y[0]) begin
      o_y = i_y >> 1;
    end else if (i_x >= i_y) begin
      // Both odd: the difference is even, so the shift loses nothing.
      o_x = (i_x - i_y) >> 1;
    end else begin
      o_y = (i_y - i_x) >> 1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/binary_gcd_engine.sv
// binary_gcd_engine: iterative Stein GCD with Begin/Complete handshake.
// Optional macro GCD_STEP_COUNT_EN adds a CALC-cycle count output (steps).
`default_nettype none

module binary_gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DONE_CYCLES = 2
) (
  input wire logic          clk,
  input wire logic          rst_n,
  binary_gcd_engine_if.slave bus
);

  localparam int KW     = k_width(WIDTH);
  localparam int HOLD_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_t             r_state, w_state_n;
  logic [WIDTH-1:0]   r_x, r_y, w_x_n, w_y_n;
  logic [KW-1:0]      r_k, w_k_n;
  logic [HOLD_W-1:0]  r_hold, w_hold_n;
  logic               r_busy, w_busy_n;
  logic               r_complete, w_complete_n;
  logic [WIDTH-1:0]   r_gcd, w_gcd_n;

  logic [WIDTH-1:0]   w_sx, w_sy, w_result;
  logic [KW-1:0]      w_sk;
  logic               w_finish;

`ifdef GCD_STEP_COUNT_EN
  localparam int CW = cnt_width(WIDTH);
  logic [CW-1:0] r_cnt, w_cnt_n, r_steps, w_steps_n;
`endif

  binary_gcd_step #(.WIDTH(WIDTH), .K_W(KW)) u_step (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_k      (r_k),
    .o_x      (w_sx),
    .o_y      (w_sy),
    .o_k      (w_sk),
    .o_finish (w_finish),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_k        <= '0;
      r_hold     <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_gcd      <= '0;
`ifdef GCD_STEP_COUNT_EN
      r_cnt      <= '0;
      r_steps    <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_x        <= w_x_n;
      r_y        <= w_y_n;
      r_k        <= w_k_n;
      r_hold     <= w_hold_n;
      r_busy     <= w_busy_n;
      r_complete <= w_complete_n;
      r_gcd      <= w_gcd_n;
`ifdef GCD_STEP_COUNT_EN
      r_cnt      <= w_cnt_n;
      r_steps    <= w_steps_n;
`endif
    end
  end

  // Outputs are computed one cycle ahead so they can be driven straight from flops.
  always_comb begin
    w_state_n    = r_state;
    w_x_n        = r_x;
    w_y_n        = r_y;
    w_k_n        = r_k;
    w_hold_n     = r_hold;
    w_busy_n     = 1'b0;
    w_complete_n = 1'b0;
    w_gcd_n      = '0;
`ifdef GCD_STEP_COUNT_EN
    w_cnt_n      = r_cnt;
    w_steps_n    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.Begin) begin
          w_state_n = S_CALC;
          w_x_n     = bus.a;
          w_y_n     = bus.b;
          w_k_n     = '0;
          w_busy_n  = 1'b1;
`ifdef GCD_STEP_COUNT_EN
          w_cnt_n   = '0;
`endif
        end
      end
      S_CALC: begin
        w_busy_n = 1'b1;
`ifdef GCD_STEP_COUNT_EN
        w_cnt_n  = r_cnt + CW'(1);
`endif
        if (w_finish) begin
          w_state_n    = S_DONE;
          w_hold_n     = '0;
          w_complete_n = 1'b1;
          w_gcd_n      = w_result;
`ifdef GCD_STEP_COUNT_EN
          w_steps_n    = r_cnt + CW'(1);
`endif
        end else begin
          w_x_n = w_sx;
          w_y_n = w_sy;
          w_k_n = w_sk;
        end
      end
      S_DONE: begin
        if (r_hold == HOLD_W'(DONE_CYCLES - 1)) begin
          w_state_n = S_IDLE;
        end else begin
          w_hold_n     = r_hold + HOLD_W'(1);
          w_busy_n     = 1'b1;
          w_complete_n = 1'b1;
          w_gcd_n      = r_gcd;
`ifdef GCD_STEP_COUNT_EN
          w_steps_n    = r_steps;
`endif
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.busy     = r_busy;
  assign bus.Complete = r_complete;
  assign bus.gcd      = r_gcd;
`ifdef GCD_STEP_COUNT_EN
  assign bus.steps    = r_steps;
`endif

endmodule

`default_nettype wire
